ff_bank_ctrl: RTL

Controller that drives the set/reset pins of a bank of edge-triggered DFFs with synchronous and asynchronous set/reset. The DFFs receive these pins; this block generates them. It accepts set/clear commands over a valid/ready handshake and produces glitch-free, registered pulses of programmable width on the bank's sync (ss/sr) and async (as/ar) inputs. It also produces the bank's power-on async reset: assert asynchronously, deassert synchronously.

---
 rtl/ff_bank_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/ff_bank_ctrl.sv
// Set/reset pin driver for a DFF bank: handshaked commands become registered,
// fixed-width pulses on the bank's sync/async set/reset pins, plus power-on reset release.
module ff_bank_ctrl #(
    parameter int HOLD_CYC    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       ar,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_op,
    output logic       cmd_ready,
    output logic       sr_o,
    output logic       ss_o,
    output logic       ar_o,
    output logic       as_o,
    output logic       busy,
    output logic       done
);

    // state   | meaning
    // BOOT    | bank held in async reset, waiting for reset release to synchronize
    // IDLE    | waiting for a command
    // HOLD_SR | sr_o asserted
    // HOLD_SS | ss_o asserted
    // HOLD_AR | ar_o asserted (low)
    // HOLD_AS | as_o asserted (low)
    // DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {
        BOOT, IDLE, HOLD_SR, HOLD_SS, HOLD_AR, HOLD_AS, DONE
    } state_t;

    localparam int         HOLD_EFF  = (HOLD_CYC < 1) ? 1 : ((HOLD_CYC > 15) ? 15 : HOLD_CYC);
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_EFF - 1);

    state_t                   state, state_d;
    logic [3:0]               cnt, cnt_d;
    logic                     accept;
    // The last synchronizer stage is the state/ar_o register itself.
    logic [SYNC_STAGES-2:0]   sync_q;

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES - 1; i++)
                sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            state <= BOOT;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        accept  = (state == IDLE) && cmd_ready && cmd_valid;
        case (state)
            BOOT: if (sync_q[SYNC_STAGES-2]) state_d = IDLE;
            IDLE: begin
                if (accept) begin
                    cnt_d = HOLD_LOAD;
                    case (cmd_op)
                        2'b00:   state_d = HOLD_SR;
                        2'b01:   state_d = HOLD_SS;
                        2'b10:   state_d = HOLD_AR;
                        default: state_d = HOLD_AS;
                    endcase
                end
            end
            HOLD_SR, HOLD_SS, HOLD_AR, HOLD_AS: begin
                if (cnt == 4'd0) state_d = DONE;
                else             cnt_d   = cnt - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = BOOT;
        endcase
    end

    // Outputs decode the next state into flops so no input reaches a pin combinationally.
    always_ff @(posedge clk or negedge ar) begin
        if (!ar) begin
            sr_o      <= 1'b0;
            ss_o      <= 1'b0;
            ar_o      <= 1'b0;
            as_o      <= 1'b1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            sr_o      <= (state_d == HOLD_SR);
            ss_o      <= (state_d == HOLD_SS);
            ar_o      <= (state_d != BOOT) && (state_d != HOLD_AR);
            as_o      <= (state_d != HOLD_AS);
            cmd_ready <= (state_d == IDLE) && (state != BOOT);
            busy      <= (state_d != IDLE);
            done      <= (state_d == DONE);
        end
    end

endmodule
